// File: rtl/r2r_pkg.sv
// r2r_pkg: shared encodings and constants for the R2R waveform sample source.
package r2r_pkg;

    typedef enum logic [1:0] {
        MODE_BUF = 2'd0,
        MODE_SAW = 2'd1,
        MODE_TRI = 2'd2,
        MODE_SQR = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam logic [7:0] MIDSCALE       = 8'h80;
    localparam logic [7:0] DEFAULT_RELOAD = 8'hFF;

    function automatic logic [7:0] square_code(input logic [7:0] phase);
        return phase[7] ? 8'hFF : 8'h00;
    endfunction

endpackage

// File: rtl/r2r_pad_sync.sv
// r2r_pad_sync: multi-flop pad synchroniser with an edge detector on the last stage.
module r2r_pad_sync #(
    parameter int unsigned STAGES   = 2,
    parameter int unsigned WIDTH    = 1,
    parameter bit          ANY_EDGE = 1'b0
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] pad,
    output logic [WIDTH-1:0] level,
    output logic             edge_det
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            stage_q[0] <= pad;
            for (int i = 1; i < int'(STAGES); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            prev_q <= stage_q[STAGES-1];
        end
    end

    assign level = stage_q[STAGES-1];

    // Strobes want a rising edge; multi-bit levels such as mode want any change.
    assign edge_det = ANY_EDGE ? |(level ^ prev_q) : |(level & ~prev_q);

endmodule

// File: rtl/r2r_wave_gen.sv
// r2r_wave_gen: saw/triangle/square generator or sample-buffer player at a divided
// sample rate, driving the 8-bit code bus of the R2R DAC control stage.
module r2r_wave_gen
    import r2r_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [7:0]             wr_data,
    input  logic                   wr_stb,
    input  logic                   div_load,
    input  logic                   buf_clr,
    input  logic                   run,
    input  logic [1:0]             mode,
    output logic [7:0]             sample,
    output logic                   sample_stb,
    output logic                   wrap,
    output logic [$clog2(DEPTH):0] buf_len
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    // ---------------------------------------------------------------- pad sync
    logic       wr_rise;
    logic       div_rise;
    logic       clr_rise;
    logic       run_s;
    logic [1:0] mode_lvl;
    logic       mode_chg;
    mode_e      mode_s;

    logic unused_wr_level;
    logic unused_div_level;
    logic unused_clr_level;
    logic unused_run_edge;

    r2r_pad_sync #(.STAGES(SYNC_STAGES), .WIDTH(1), .ANY_EDGE(1'b0)) u_sync_wr (
        .clk      (clk),
        .n_rst    (n_rst),
        .pad      (wr_stb),
        .level    (unused_wr_level),
        .edge_det (wr_rise)
    );

    r2r_pad_sync #(.STAGES(SYNC_STAGES), .WIDTH(1), .ANY_EDGE(1'b0)) u_sync_div (
        .clk      (clk),
        .n_rst    (n_rst),
        .pad      (div_load),
        .level    (unused_div_level),
        .edge_det (div_rise)
    );

    r2r_pad_sync #(.STAGES(SYNC_STAGES), .WIDTH(1), .ANY_EDGE(1'b0)) u_sync_clr (
        .clk      (clk),
        .n_rst    (n_rst),
        .pad      (buf_clr),
        .level    (unused_clr_level),
        .edge_det (clr_rise)
    );

    r2r_pad_sync #(.STAGES(SYNC_STAGES), .WIDTH(1), .ANY_EDGE(1'b0)) u_sync_run (
        .clk      (clk),
        .n_rst    (n_rst),
        .pad      (run),
        .level    (run_s),
        .edge_det (unused_run_edge)
    );

    r2r_pad_sync #(.STAGES(SYNC_STAGES), .WIDTH(2), .ANY_EDGE(1'b1)) u_sync_mode (
        .clk      (clk),
        .n_rst    (n_rst),
        .pad      (mode),
        .level    (mode_lvl),
        .edge_det (mode_chg)
    );

    assign mode_s = mode_e'(mode_lvl);

    // ---------------------------------------------------------------- divider
    logic [DIV_W-1:0] reload_q;
    logic [DIV_W-1:0] count_q;
    logic             tick;

    // A reload restarts the period, so no tick is issued on the load cycle.
    assign tick = run_s && (count_q == '0) && !div_rise;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            reload_q <= DIV_W'(DEFAULT_RELOAD);
            count_q  <= DIV_W'(DEFAULT_RELOAD);
        end else if (div_rise) begin
            reload_q <= DIV_W'(wr_data);
            count_q  <= DIV_W'(wr_data);
        end else if (!run_s || (count_q == '0)) begin
            count_q <= reload_q;
        end else begin
            count_q <= count_q - DIV_W'(1);
        end
    end

    // ---------------------------------------------------------------- sample buffer
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp_q;
    logic [LW-1:0] len_q;
    logic          do_write;

    // Clear wins over a coincident write.
    assign do_write = wr_rise && !clr_rise;

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wp_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wp_q  <= '0;
            len_q <= '0;
        end else if (clr_rise) begin
            wp_q  <= '0;
            len_q <= '0;
        end else if (do_write) begin
            wp_q <= wp_q + AW'(1);
            if (len_q != LW'(DEPTH)) begin
                len_q <= len_q + LW'(1);
            end
        end
    end

    assign buf_len = len_q;

    // ---------------------------------------------------------------- generator
    logic [7:0]    phase_q;
    logic [7:0]    phase_d;
    dir_e          dir_q;
    dir_e          dir_d;
    logic [AW-1:0] idx_q;
    logic [AW-1:0] idx_d;
    logic          lapped_q;
    logic          lapped_d;
    logic          idx_last;
    logic [7:0]    gen_sample;
    logic          gen_wrap;

    assign idx_last = (({1'b0, idx_q} + LW'(1)) == len_q);

    always_comb begin
        phase_d    = phase_q;
        dir_d      = dir_q;
        idx_d      = idx_q;
        lapped_d   = lapped_q;
        gen_sample = sample;
        gen_wrap   = 1'b0;
        unique case (mode_s)
            MODE_BUF: begin
                if (len_q != '0) begin
                    gen_sample = mem[idx_q];
                    // Index 0 after at least one play means the buffer came round again.
                    gen_wrap   = lapped_q && (idx_q == '0);
                    lapped_d   = 1'b1;
                    idx_d      = idx_last ? '0 : idx_q + AW'(1);
                end else begin
                    gen_sample = MIDSCALE;
                end
            end
            MODE_SAW: begin
                phase_d    = phase_q + 8'd1;
                gen_sample = phase_d;
                gen_wrap   = (phase_d == 8'h00);
            end
            MODE_TRI: begin
                phase_d    = (dir_q == DIR_UP) ? phase_q + 8'd1 : phase_q - 8'd1;
                gen_sample = phase_d;
                gen_wrap   = (dir_q == DIR_DOWN) && (phase_d == 8'h00);
                if (phase_d == 8'hFF) begin
                    dir_d = DIR_DOWN;
                end else if (phase_d == 8'h00) begin
                    dir_d = DIR_UP;
                end
            end
            MODE_SQR: begin
                phase_d    = phase_q + 8'd1;
                gen_sample = square_code(phase_d);
                gen_wrap   = (phase_d == 8'h00);
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sample     <= MIDSCALE;
            sample_stb <= 1'b0;
            wrap       <= 1'b0;
            phase_q    <= 8'h00;
            dir_q      <= DIR_UP;
            idx_q      <= '0;
            lapped_q   <= 1'b0;
        end else begin
            sample_stb <= 1'b0;
            wrap       <= 1'b0;
            if (mode_chg) begin
                // Restart the new waveform from its origin; sample holds until the next tick.
                phase_q  <= 8'h00;
                dir_q    <= DIR_UP;
                idx_q    <= '0;
                lapped_q <= 1'b0;
            end else begin
                if (tick) begin
                    sample     <= gen_sample;
                    sample_stb <= 1'b1;
                    wrap       <= gen_wrap;
                    phase_q    <= phase_d;
                    dir_q      <= dir_d;
                    idx_q      <= idx_d;
                    lapped_q   <= lapped_d;
                end
                if (clr_rise) begin
                    idx_q    <= '0;
                    lapped_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_r2r_wave_gen.sv
// tb_r2r_wave_gen: randomized scoreboard bench for r2r_wave_gen against a
// tick-count reference model of the waveform and buffer rules.
module tb_r2r_wave_gen;

    localparam int DEPTH = 16;
    localparam int SYNC  = 2;

    logic       clk      = 1'b0;
    logic       n_rst    = 1'b0;
    logic [7:0] wr_data  = 8'h00;
    logic       wr_stb   = 1'b0;
    logic       div_load = 1'b0;
    logic       buf_clr  = 1'b0;
    logic       run      = 1'b0;
    logic [1:0] mode     = 2'd0;
    logic [7:0] sample;
    logic       sample_stb;
    logic       wrap;
    logic [4:0] buf_len;

    r2r_wave_gen #(
        .DEPTH       (DEPTH),
        .DIV_W       (8),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .wr_data    (wr_data),
        .wr_stb     (wr_stb),
        .div_load   (div_load),
        .buf_clr    (buf_clr),
        .run        (run),
        .mode       (mode),
        .sample     (sample),
        .sample_stb (sample_stb),
        .wrap       (wrap),
        .buf_len    (buf_len)
    );

    always #50 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // ---------------------------------------------------------------- reference model
    typedef struct {
        logic [7:0] s;
        logic       w;
        int         c;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] wq[$];          // bytes written since the last clear
    int         k        = 0;   // ticks since the waveform restarted
    int         bk       = 0;   // buffer plays since restart/clear
    int         reload   = 255;
    int         cur_mode = 0;
    logic [7:0] last_exp = 8'h80;

    function automatic int model_len();
        return (wq.size() < DEPTH) ? wq.size() : DEPTH;
    endfunction

    // Slot i holds the most recent write whose sequence number is i modulo DEPTH.
    function automatic logic [7:0] buf_entry(input int i);
        int n;
        int w;
        n = wq.size();
        w = i + DEPTH * ((n - 1 - i) / DEPTH);
        return wq[w];
    endfunction

    task automatic model_next(output logic [7:0] s, output logic w);
        int len;
        int t;
        case (cur_mode)
            0: begin
                len = model_len();
                if (len == 0) begin
                    s = 8'h80;
                    w = 1'b0;
                end else begin
                    s = buf_entry(bk % len);
                    w = (bk > 0) && (bk % len == 0);
                    bk++;
                end
            end
            1: begin
                k++;
                s = 8'(k % 256);
                w = (k % 256 == 0);
            end
            2: begin
                k++;
                t = k % 510;
                s = 8'((t <= 255) ? t : 510 - t);
                w = (t == 0);
            end
            default: begin
                k++;
                s = (k % 256 >= 128) ? 8'hFF : 8'h00;
                w = (k % 256 == 0);
            end
        endcase
    endtask

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin
        exp_t it;
        if (!n_rst) begin
            last_exp = 8'h80;
        end else if (sample_stb) begin
            if (exp_q.size() == 0) begin
                check("unexpected sample_stb", 32'(sample_stb), 32'd0);
            end else begin
                it = exp_q.pop_front();
                check("sample value", 32'(sample), 32'(it.s));
                check("wrap flag", 32'(wrap), 32'(it.w));
                check("strobe cycle", 32'(cyc), 32'(it.c));
                last_exp = it.s;
            end
        end else begin
            check("sample hold", 32'(sample), 32'(last_exp));
            check("wrap without strobe", 32'(wrap), 32'd0);
        end
    end

    // ---------------------------------------------------------------- stimulus
    task automatic pulse(input logic do_wr, input logic do_div, input logic do_clr,
                         input logic [7:0] data);
        @(posedge clk);
        #1;
        wr_data  = data;
        wr_stb   = do_wr;
        div_load = do_div;
        buf_clr  = do_clr;
        repeat (SYNC + 2) @(posedge clk);
        #1;
        wr_stb   = 1'b0;
        div_load = 1'b0;
        buf_clr  = 1'b0;
        repeat (SYNC + 2) @(posedge clk);
        #1;
        if (do_clr) begin
            wq.delete();
            bk = 0;
        end else if (do_wr) begin
            wq.push_back(data);
        end
        if (do_div) reload = int'(data);
        check("buf_len", 32'(buf_len), 32'(model_len()));
    endtask

    task automatic set_mode(input int m);
        @(posedge clk);
        #1;
        mode = 2'(m);
        repeat (SYNC + 3) @(posedge clk);
        if (m != cur_mode) begin
            k  = 0;
            bk = 0;
        end
        cur_mode = m;
    endtask

    // run is high for w cycles; the divider yields one tick every reload+1 of them.
    task automatic run_window(input int w);
        int         base;
        int         n;
        logic [7:0] s;
        logic       wr;
        @(posedge clk);
        #1;
        run  = 1'b1;
        base = cyc;
        n    = w / (reload + 1);
        for (int i = 1; i <= n; i++) begin
            model_next(s, wr);
            exp_q.push_back('{s: s, w: wr, c: base + SYNC + i * (reload + 1)});
        end
        repeat (w) @(posedge clk);
        #1;
        run = 1'b0;
        repeat (SYNC + 4) @(posedge clk);
        #1;
        check("window drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        int         m;
        logic [7:0] s;
        logic       wr;
        int         base;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset sample", 32'(sample), 32'h80);
        check("reset sample_stb", 32'(sample_stb), 32'd0);
        check("reset wrap", 32'(wrap), 32'd0);
        check("reset buf_len", 32'(buf_len), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (4) @(posedge clk);

        // Saw at 4 cycles per tick through a full period
        set_mode(1);
        pulse(1'b0, 1'b1, 1'b0, 8'h03);
        run_window(260 * 4);

        // Triangle at full rate, two periods
        set_mode(2);
        pulse(1'b0, 1'b1, 1'b0, 8'h00);
        run_window(1020);

        // Buffer playback of three samples
        set_mode(0);
        pulse(1'b0, 1'b0, 1'b1, 8'h00);
        pulse(1'b1, 1'b0, 1'b0, 8'h10);
        pulse(1'b1, 1'b0, 1'b0, 8'h20);
        pulse(1'b1, 1'b0, 1'b0, 8'h30);
        pulse(1'b0, 1'b1, 1'b0, 8'h01);
        run_window(8 * 2);

        // Overfill, overwrite while parked, then clear
        pulse(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i <= 16; i++) pulse(1'b1, 1'b0, 1'b0, 8'(i));
        run_window(20 * 2);
        pulse(1'b1, 1'b0, 1'b0, 8'hA5);
        run_window(16 * 2);
        pulse(1'b0, 1'b0, 1'b1, 8'h00);
        run_window(3 * 2);

        // Coincident strobes
        pulse(1'b1, 1'b0, 1'b0, 8'h11);
        pulse(1'b1, 1'b0, 1'b1, 8'h22);
        pulse(1'b1, 1'b1, 1'b0, 8'h02);
        run_window(3 * 3);

        // Square with stop/resume and an uneven window
        set_mode(3);
        pulse(1'b0, 1'b1, 1'b0, 8'h01);
        run_window(300 * 2);
        run_window(220 * 2 + 1);

        // Randomised mix
        for (int it = 0; it < 8; it++) begin
            m = int'($urandom_range(0, 3));
            set_mode(m);
            if (m == 0) begin
                pulse(1'b0, 1'b0, 1'b1, 8'h00);
                n = int'($urandom_range(0, 20));
                for (int i = 0; i < n; i++) pulse(1'b1, 1'b0, 1'b0, 8'($urandom));
            end
            pulse(1'b0, 1'b1, 1'b0, 8'($urandom_range(0, 6)));
            run_window(int'($urandom_range(8, 120)));
        end

        // Reset in the middle of a saw at sample 0x5A
        set_mode(2);
        set_mode(1);
        pulse(1'b0, 1'b1, 1'b0, 8'h03);
        @(posedge clk);
        #1;
        run  = 1'b1;
        base = cyc;
        for (int i = 1; i <= 90; i++) begin
            model_next(s, wr);
            exp_q.push_back('{s: s, w: wr, c: base + SYNC + i * 4});
        end
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("pre-reset drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        #2;
        n_rst = 1'b0;
        #1;
        check("async reset sample", 32'(sample), 32'h80);
        check("async reset sample_stb", 32'(sample_stb), 32'd0);
        check("async reset wrap", 32'(wrap), 32'd0);
        run    = 1'b0;
        k      = 0;
        bk     = 0;
        reload = 255;
        wq.delete();
        repeat (3) @(posedge clk);
        #1;
        check("async reset buf_len", 32'(buf_len), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (SYNC + 3) @(posedge clk);
        pulse(1'b0, 1'b1, 1'b0, 8'h03);
        run_window(3 * 4);

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
